i2s_transmitter: RTL and testbench

Serialises processed 16-bit audio samples onto an I2S link to the output DAC. It is the transmit end of the sample path: the DSP chain hands one parallel sample per audio frame over a valid/ready handshake, and the block generates BCLK, LRCLK and SDATA. It buffers one pending sample and plays it on both channels (mono guitar signal). It flags underrun when the chain is late.

---
 rtl/i2s_transmitter.sv | 108 ++++++++++
 tb/tb_i2s_transmitter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S transmitter: takes one 16-bit sample per frame over valid/ready and
// plays it on both channel slots, flagging an underrun when no sample is waiting.
module i2s_transmitter #(
  parameter int size      = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [size-1:0] data,
  output logic            ready,
  output logic            bclk,
  output logic            lrclk,
  output logic            sdata,
  output logic            underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;

  logic [DIV_W-1:0]       r_div_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic                   r_bclk;
  logic                   r_lrclk;
  logic                   r_sdata;
  logic                   r_underrun;
  logic                   r_ready;
  logic                   r_pending_full;
  logic signed [size-1:0] r_pending;
  logic signed [size-1:0] r_frame;

  logic                   w_wrap;
  logic                   w_fe;
  logic                   w_load;
  logic                   w_accept;
  logic [BIT_W-1:0]       w_bit_next;
  logic [BIT_W-1:0]       w_slot_pos;
  logic                   w_in_word;
  logic [IDX_W-1:0]       w_frame_idx;
  logic                   w_sdata_next;

  assign w_wrap     = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_fe       = w_wrap && r_bclk;
  assign w_load     = w_fe && (r_bit_cnt == BIT_W'(2 * SLOT_BITS - 1));
  assign w_accept   = valid && r_ready;
  assign w_bit_next = (r_bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : r_bit_cnt + 1'b1;

  // Output bit for the new bit count: one BCLK of delay after the slot edge, MSB first.
  assign w_slot_pos   = (w_bit_next >= BIT_W'(SLOT_BITS)) ? w_bit_next - BIT_W'(SLOT_BITS)
                                                           : w_bit_next;
  assign w_in_word    = (w_slot_pos != '0) && (w_slot_pos <= BIT_W'(size));
  assign w_frame_idx  = IDX_W'(BIT_W'(size) - w_slot_pos);
  assign w_sdata_next = w_in_word && r_frame[w_frame_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_bclk         <= 1'b0;
      r_lrclk        <= 1'b0;
      r_sdata        <= 1'b0;
      r_underrun     <= 1'b0;
      r_ready        <= 1'b0;
      r_pending_full <= 1'b0;
      r_frame        <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (w_fe) begin
        r_bit_cnt <= w_bit_next;
        r_lrclk   <= (w_bit_next >= BIT_W'(SLOT_BITS));
        r_sdata   <= w_sdata_next;
        if (w_load) begin
          if (r_pending_full) begin
            r_frame <= r_pending;
          end else begin
            r_frame    <= '0;
            r_underrun <= 1'b1;
          end
        end
      end

      // The load reads the buffer state before this edge, so an accept on the load clk never bypasses.
      if (w_accept) begin
        r_pending      <= data;
        r_pending_full <= 1'b1;
      end else if (w_load && r_pending_full) begin
        r_pending_full <= 1'b0;
      end
      r_ready <= !(w_accept || (r_pending_full && !w_load));
    end
  end

  assign ready    = r_ready;
  assign bclk     = r_bclk;
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: reset/idle, single sample, backpressure,
// load/accept collision, mid-frame reset and a streamed ramp.
module tb_i2s_transmitter;
  localparam int SIZE = 16;
  localparam int SLOT = 32;
  localparam int DIV  = 4;
  localparam int FRAME_FE = 2 * SLOT;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            valid = 1'b0;
  logic [SIZE-1:0] data = '0;
  logic            ready, bclk, lrclk, sdata, underrun;

  i2s_transmitter #(.size(SIZE), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .ready(ready),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_n = 0;
  int un_cnt = 0;
  int acc_cnt = 0;
  int last_un_cyc = 0;
  int load_cyc = 0;
  int fe1_cyc = 0;
  int timeouts = 0;
  bit feed_en = 1'b0;
  logic [SIZE-1:0] ramp = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk: sample just after the edge, track falling BCLK edges, underruns and accepts.
  task automatic step();
    logic pb, acc;
    pb  = bclk;
    acc = valid && ready;
    @(posedge clk);
    #1;
    cyc++;
    if (pb && !bclk) begin
      fe_n++;
      if (fe_n % FRAME_FE == 0) load_cyc = cyc;
    end
    if (underrun) begin
      un_cnt++;
      last_un_cyc = cyc;
    end
    if (acc) begin
      acc_cnt++;
      if (feed_en) begin
        ramp = ramp + 1'b1;
        data = ramp;
      end
    end
  endtask

  task automatic wait_fe();
    int start;
    start = fe_n;
    for (int i = 0; i < 4 * DIV && fe_n == start; i++) step();
    if (fe_n == start) timeouts++;
  endtask

  task automatic wait_load();
    for (int i = 0; i < FRAME_FE + 2; i++) begin
      wait_fe();
      if (fe_n % FRAME_FE == 0) break;
    end
  endtask

  // Starting right after a load FE, record the 63 remaining FEs of the frame.
  task automatic capture(output logic [SIZE-1:0] l, output logic [SIZE-1:0] r,
                         output logic pad_ok, output logic lr_ok);
    logic b [0:FRAME_FE-1];
    pad_ok = 1'b1;
    lr_ok  = 1'b1;
    l = '0;
    r = '0;
    for (int k = 0; k < FRAME_FE; k++) b[k] = 1'b0;
    for (int k = 1; k < FRAME_FE; k++) begin
      wait_fe();
      if (k == 1) fe1_cyc = cyc;
      b[k] = sdata;
      if (lrclk !== (k >= SLOT)) lr_ok = 1'b0;
    end
    for (int i = 0; i < SIZE; i++) begin
      l[SIZE-1-i] = b[1 + i];
      r[SIZE-1-i] = b[SLOT + 1 + i];
    end
    for (int k = SIZE + 1; k < SLOT; k++) begin
      if (b[k] !== 1'b0 || b[SLOT + k] !== 1'b0) pad_ok = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIZE-1:0] l, r;
    logic pd, lr;
    int bclk_err, sd_hi, un_first, first_rdy, base, un0, rdy1;

    // Reset and idle
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_outs", {27'd0, bclk, lrclk, sdata, ready, underrun}, 32'd0);
    rst = 1'b1;
    cyc = 0; fe_n = 0; un_cnt = 0;
    step();
    chk("ready_after_release", ready, 1);
    bclk_err = 0; sd_hi = 0; un_first = -1;
    while (cyc < 1100) begin
      step();
      if (bclk !== 1'((cyc / DIV) % 2)) bclk_err++;
      if (sdata !== 1'b0) sd_hi++;
      if (underrun && un_cnt == 1) un_first = cyc;
    end
    chk("idle_bclk_period", bclk_err, 0);
    chk("idle_sdata_zero", sd_hi, 0);
    chk("idle_underrun_count", un_cnt, 2);
    chk("idle_underrun_first", un_first, 512);
    chk("idle_underrun_second", last_un_cyc, 1024);

    // Single sample in frame 0
    rst = 1'b0;
    step(); step();
    chk("rst2_outs", {27'd0, bclk, lrclk, sdata, ready, underrun}, 32'd0);
    rst = 1'b1;
    cyc = 0; fe_n = 0; un_cnt = 0; acc_cnt = 0;
    step();
    valid = 1'b1; data = 16'hA5C3;
    step();
    valid = 1'b0;
    chk("single_accept", acc_cnt, 1);
    chk("single_ready_fall", ready, 0);
    wait_load();
    chk("single_load_cyc", load_cyc, 512);
    chk("single_no_underrun", un_cnt, 0);
    chk("single_ready_rise", ready, 1);
    capture(l, r, pd, lr);
    chk("single_left", l, 16'hA5C3);
    chk("single_right", r, 16'hA5C3);
    chk("single_pad", pd, 1);
    chk("single_lrclk", lr, 1);
    chk("single_msb_latency", fe1_cyc - load_cyc, 2 * DIV);

    // Backpressure
    wait_load();
    valid = 1'b1; data = 16'h5A5A;
    step();
    data = 16'h1234;
    base = acc_cnt; un0 = un_cnt; first_rdy = -1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (ready && first_rdy < 0) first_rdy = cyc;
    end
    valid = 1'b0;
    chk("bp_load_cyc", load_cyc, 1536);
    chk("bp_ready_first_at_load", first_rdy, load_cyc);
    chk("bp_one_accept", acc_cnt - base, 1);
    chk("bp_no_underrun", un_cnt - un0, 0);
    wait_load();
    capture(l, r, pd, lr);
    chk("bp_frame_left", l, 16'h1234);
    chk("bp_frame_right", r, 16'h1234);

    // Load/accept collision on the wrap clk
    repeat (2 * DIV - 1) step();
    valid = 1'b1; data = 16'h8001;
    base = acc_cnt;
    step();
    valid = 1'b0;
    chk("col_underrun", underrun, 1);
    chk("col_is_load", fe_n % FRAME_FE, 0);
    chk("col_accept", acc_cnt - base, 1);
    capture(l, r, pd, lr);
    chk("col_zero_frame", {l, r}, 32'd0);
    wait_fe();
    chk("col_next_no_underrun", underrun, 0);
    capture(l, r, pd, lr);
    chk("col_next_left", l, 16'h8001);
    chk("col_next_right", r, 16'h8001);
    chk("col_next_pad", pd, 1);

    // Reset mid-frame with the buffer full
    valid = 1'b1; data = 16'h7777;
    step();
    valid = 1'b0;
    wait_fe();
    valid = 1'b1; data = 16'h4321;
    step();
    valid = 1'b0;
    chk("mid_pending_full", ready, 0);
    for (int i = 0; i < FRAME_FE && fe_n % FRAME_FE != 20; i++) wait_fe();
    repeat (DIV) step();
    chk("mid_bclk_high", bclk, 1);
    rst = 1'b0;
    step();
    chk("mid_rst_outs", {27'd0, bclk, lrclk, sdata, ready, underrun}, 32'd0);
    step();
    rst = 1'b1;
    cyc = 0; fe_n = 0; un_cnt = 0; bclk_err = 0; un_first = -1; rdy1 = 0;
    while (cyc < 520) begin
      step();
      if (cyc == 1) rdy1 = ready;
      if (bclk !== 1'((cyc / DIV) % 2)) bclk_err++;
      if (underrun && un_cnt == 1) un_first = cyc;
    end
    chk("mid_ready_after_release", rdy1, 1);
    chk("mid_bclk_period", bclk_err, 0);
    chk("mid_underrun_first", un_first, 512);
    chk("mid_underrun_count", un_cnt, 1);

    // Streaming ramp
    ramp = '0; data = '0; feed_en = 1'b1; valid = 1'b1;
    un0 = un_cnt;
    wait_load();
    for (int f = 0; f < 8; f++) begin
      capture(l, r, pd, lr);
      chk($sformatf("stream_frame%0d", f), {l, r}, {16'(f), 16'(f)});
      wait_fe();
    end
    feed_en = 1'b0; valid = 1'b0;
    chk("stream_no_underrun", un_cnt - un0, 0);

    chk("fe_timeouts", timeouts, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
